// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the captured request.
package dmem_pkg;

    // Widest supported word/address; the captured request stores fields at these widths.
    localparam int MAX_IDX_W  = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_BEN_W  = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic [MAX_IDX_W-1:0]  idx;
        logic                  is_write;
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_BEN_W-1:0]  ben;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enables and a registered read port.
module dmem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    ben,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < NB; b++) begin
                if (ben[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling data-memory responder with replay-style acknowledge matching.
// Define DMEM_RESP_BOUNDS_CHECK_EN to add dmem_err and drop out-of-range accesses.
module dmem_responder import dmem_pkg::*; #(
    parameter int REG_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int RD_LATENCY     = 2,
    parameter int WR_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
    input  logic                      dmem_rd_en,
    input  logic                      dmem_wr_en,
    input  logic [REG_WIDTH-1:0]      dmem_wr_data,
    input  logic [REG_WIDTH/8-1:0]    dmem_wr_ben,
    output logic                      dmem_rd_ack,
    output logic                      dmem_wr_ack,
    output logic [REG_WIDTH-1:0]      dmem_rd_data
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
    ,
    output logic                      dmem_err
`endif
);

    localparam int NB      = REG_WIDTH / 8;
    localparam int OFF     = $clog2(NB);
    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    dmem_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    dmem_req_t            req_q, req_d;
    logic                 rd_zero_q;

    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic [MAX_IDX_W-1:0]      word_idx_ext;
    logic                      idx_match;
    logic                      access;
    logic                      oob;
    logic [REG_WIDTH-1:0]      arr_rdata;

    assign word_idx     = dmem_addr >> OFF;
    assign word_idx_ext = MAX_IDX_W'(word_idx);
    assign idx_match    = (word_idx_ext == req_q.idx);

`ifdef DMEM_RESP_BOUNDS_CHECK_EN
    assign oob = (req_q.idx >= MAX_IDX_W'(DEPTH_WORDS));
`else
    assign oob = 1'b0;
`endif

    // Gating with reset keeps an abandoned write from reaching the array.
    assign access = (state_q == StBusy) && (cnt_q == '0) && !reset;

    dmem_array #(
        .WIDTH (REG_WIDTH),
        .DEPTH (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access && !oob),
        .we    (req_q.is_write),
        .addr  (req_q.idx[AW-1:0]),
        .wdata (req_q.data[REG_WIDTH-1:0]),
        .ben   (req_q.ben[NB-1:0]),
        .rdata (arr_rdata)
    );

    always_comb begin
        dmem_rd_ack = (state_q == StDone) && !req_q.is_write && dmem_rd_en && !dmem_wr_en
                      && idx_match;
        dmem_wr_ack = (state_q == StDone) && req_q.is_write && dmem_wr_en && idx_match
                      && (MAX_DATA_W'(dmem_wr_data) == req_q.data)
                      && (MAX_BEN_W'(dmem_wr_ben) == req_q.ben);
    end

`ifdef DMEM_RESP_BOUNDS_CHECK_EN
    assign dmem_err = (dmem_rd_ack || dmem_wr_ack) && oob;
`endif

    assign dmem_rd_data = rd_zero_q ? '0 : arr_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            StIdle: begin
                if (dmem_rd_en || dmem_wr_en) begin
                    req_d.idx      = word_idx_ext;
                    req_d.is_write = dmem_wr_en;
                    req_d.data     = MAX_DATA_W'(dmem_wr_data);
                    req_d.ben      = MAX_BEN_W'(dmem_wr_ben);
                    cnt_d          = dmem_wr_en ? CNT_W'(WR_LATENCY - 1)
                                                : CNT_W'(RD_LATENCY - 1);
                    state_d        = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            StDone: begin
                if (dmem_rd_ack || dmem_wr_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= '0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            // An out-of-range read reports zero until the next read completes.
            if (access && !req_q.is_write) rd_zero_q <= oob;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic vs a word model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic        dmem_rd_en, dmem_wr_en;
    logic [31:0] dmem_wr_data;
    logic [3:0]  dmem_wr_ben;
    logic        dmem_rd_ack, dmem_wr_ack;
    logic [31:0] dmem_rd_data;
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
    logic        dmem_err;
`endif

    dmem_responder #(
        .REG_WIDTH      (32),
        .MEM_ADDR_WIDTH (32),
        .DEPTH_WORDS    (1024),
        .RD_LATENCY     (RD_LAT),
        .WR_LATENCY     (WR_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dmem_addr    (dmem_addr),
        .dmem_rd_en   (dmem_rd_en),
        .dmem_wr_en   (dmem_wr_en),
        .dmem_wr_data (dmem_wr_data),
        .dmem_wr_ben  (dmem_wr_ben),
        .dmem_rd_ack  (dmem_rd_ack),
        .dmem_wr_ack  (dmem_wr_ack),
        .dmem_rd_data (dmem_rd_data)
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
        ,
        .dmem_err     (dmem_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_m [1024];
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_oob(input logic [31:0] a);
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
        return (a[31:2] >= 30'd1024);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] acks();
        return {dmem_rd_ack, dmem_wr_ack};
    endfunction

    // Present one request at a negedge and hold it until the ack cycle has passed.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input string tag);
        int   lat = wr ? WR_LAT : RD_LAT;
        int   w   = int'(a[11:2]);
        logic oob = is_oob(a);
        dmem_addr = a; dmem_rd_en = rd; dmem_wr_en = wr; dmem_wr_data = d; dmem_wr_ben = be;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk({tag, " busy acks"}, 32'(acks()), 32'd0);
        end
        @(negedge clk);
        if (wr) begin
            if (!oob) begin
                for (int b = 0; b < 4; b++) if (be[b]) mem_m[w][8*b +: 8] = d[8*b +: 8];
            end
            chk({tag, " wr ack"}, 32'(acks()), 32'd1);
        end else begin
            last_rd = oob ? 32'd0 : mem_m[w];
            chk({tag, " rd ack"}, 32'(acks()), 32'd2);
        end
        chk({tag, " rd_data"}, dmem_rd_data, last_rd);
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
        chk({tag, " err"}, 32'(dmem_err), 32'(oob));
`endif
        @(negedge clk);
        chk({tag, " idle acks"}, 32'(acks()), 32'd0);
        dmem_rd_en = 1'b0; dmem_wr_en = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int          w, k;

        reset = 1'b1; dmem_addr = '0; dmem_rd_en = 0; dmem_wr_en = 0;
        dmem_wr_data = '0; dmem_wr_ben = '0; last_rd = '0;
        repeat (3) @(negedge clk);
        chk("reset acks", 32'(acks()), 32'd0);
        chk("reset rd_data", dmem_rd_data, 32'd0);
        chk("reset state", 32'(dut.state_q), 32'(StIdle));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i <= 32; i++) issue(0, 1, 32'(i * 4), $urandom, 4'hF, "init");

        issue(0, 1, 32'h40, 32'hDEADBEEF, 4'hF, "wr40");
        issue(1, 0, 32'h40, 32'h0, 4'h0, "rd40");
        chk("rd40 value", dmem_rd_data, 32'hDEADBEEF);

        issue(0, 1, 32'h40, 32'h000000AA, 4'h1, "wr40 byte");
        issue(1, 0, 32'h40, 32'h0, 4'h0, "rd40 merge");
        chk("merge value", dmem_rd_data, 32'hDEADBEAA);

        // Replay: wrong address during DONE, then the original read.
        dmem_addr = 32'h40; dmem_rd_en = 1'b1;
        @(negedge clk); chk("replay busy1", 32'(acks()), 32'd0);
        @(negedge clk); chk("replay busy2", 32'(acks()), 32'd0);
        dmem_addr = 32'h80;
        @(negedge clk); chk("replay 80 c1", 32'(acks()), 32'd0);
        chk("replay state c1", 32'(dut.state_q), 32'(StDone));
        @(negedge clk); chk("replay 80 c2", 32'(acks()), 32'd0);
        chk("replay state c2", 32'(dut.state_q), 32'(StDone));
        dmem_addr = 32'h40;
        #1;
        chk("replay ack", 32'(acks()), 32'd2);
        chk("replay data", dmem_rd_data, 32'hDEADBEAA);
        last_rd = 32'hDEADBEAA;
        @(negedge clk); chk("replay idle", 32'(acks()), 32'd0);
        dmem_rd_en = 1'b0;

        // Reset while a write is in flight.
        issue(0, 1, 32'h44, 32'h55667788, 4'hF, "wr44 prior");
        dmem_addr = 32'h44; dmem_wr_en = 1'b1; dmem_wr_data = 32'h11223344; dmem_wr_ben = 4'hF;
        @(negedge clk);
        chk("abort busy", 32'(dut.state_q), 32'(StBusy));
        reset = 1'b1; dmem_wr_en = 1'b0;
        @(negedge clk);
        chk("abort state", 32'(dut.state_q), 32'(StIdle));
        chk("abort acks", 32'(acks()), 32'd0);
        chk("abort rd_data", dmem_rd_data, 32'd0);
        last_rd = 32'd0;
        reset = 1'b0;
        @(negedge clk);
        issue(1, 0, 32'h44, 32'h0, 4'h0, "rd44");
        chk("rd44 value", dmem_rd_data, 32'h55667788);

        // Address 0x1000 is word 1024: dropped with error, or aliases word 0.
        issue(0, 1, 32'h0, 32'h0BADF00D, 4'hF, "wr0");
        issue(1, 0, 32'h1000, 32'h0, 4'h0, "rd1000");
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
        chk("rd1000 value", dmem_rd_data, 32'h0);
`else
        chk("rd1000 value", dmem_rd_data, 32'h0BADF00D);
`endif

        for (int i = 0; i < 40; i++) begin
            w = int'($urandom_range(0, 32));
            a = 32'(w * 4) + 32'($urandom_range(0, 3));
`ifndef DMEM_RESP_BOUNDS_CHECK_EN
            a = a + 32'h1000 * 32'($urandom_range(0, 3));
`endif
            d = $urandom;
            k = int'($urandom_range(0, 2));
            case (k)
                0:       issue(1, 0, a, d, 4'($urandom), "rand rd");
                1:       issue(0, 1, a, d, 4'($urandom), "rand wr");
                default: issue(1, 1, a, d, 4'($urandom), "rand rdwr");
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, array depth in words (power of two).
REQ-004 SHALL have parameter RD_LATENCY, default 2, cycles from capture to read completion (>=1).
REQ-005 SHALL have parameter WR_LATENCY, default 1, cycles from capture to write commit (>=1).
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port dmem_addr, input, MEM_ADDR_WIDTH, byte address (low log2(REG_WIDTH/8) bits ignored).
REQ-009 SHALL have ports dmem_rd_en and dmem_wr_en, input, 1 each, read and write requests.
REQ-010 SHALL have ports dmem_wr_data (input, REG_WIDTH) and dmem_wr_ben (input, REG_WIDTH/8), write data and byte enables.
REQ-011 SHALL have ports dmem_rd_ack and dmem_wr_ack, output, 1 each, completion acknowledges.
REQ-012 SHALL have port dmem_rd_data, output, REG_WIDTH, read word.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 In IDLE, rd_en|wr_en SHALL capture word index, kind, wr_data and wr_ben, load counter with latency-1, and enter BUSY next cycle.
REQ-015 rd_en and wr_en both high SHALL be captured as a write; no read is performed and rd_ack stays 0.
REQ-016 In BUSY, the counter SHALL decrement each cycle; at zero, the access is performed and the FSM enters DONE next cycle.
REQ-017 A write SHALL update only bytes with ben=1; a read SHALL register the array word into dmem_rd_data.
REQ-018 dmem_rd_data SHALL hold its value from read completion until the next read completes.
REQ-019 In DONE, acks SHALL be combinational: rd_ack=1 iff rd_en=1, wr_en=0, and word index equals captured read index; wr_ack=1 iff wr_en=1 and index, wr_data and wr_ben equal the captured write.
REQ-020 An asserted ack SHALL return the FSM to IDLE next cycle; new requests SHALL be captured only in IDLE, so the earliest next capture is one cycle after the ack.
REQ-021 In DONE with a non-matching or absent request, the FSM SHALL hold DONE with acks 0 until the original request is re-presented (barrel-hart replay).
REQ-022 Acks SHALL be 0 in IDLE and BUSY.
REQ-023 A read following an acked write to the same word SHALL return the written bytes merged with the old unwritten bytes.

Reset
REQ-024 reset SHALL force IDLE, counter 0, dmem_rd_data 0, acks 0, captured request cleared.
REQ-025 reset during BUSY SHALL abandon the request; an uncommitted write SHALL NOT modify the array.
REQ-026 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_RESP_BOUNDS_CHECK_EN SHALL select out-of-range handling.
REQ-028 With DMEM_RESP_BOUNDS_CHECK_EN defined, an extra output dmem_err (1 bit) SHALL be present; word index >= DEPTH_WORDS SHALL drop writes, return 0 for reads, and assert dmem_err together with the ack; dmem_err resets to 0.
REQ-029 Without DMEM_RESP_BOUNDS_CHECK_EN, dmem_err SHALL be absent and the word index SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-030 Package dmem_pkg SHALL hold the FSM state enum and the captured-request struct (index, kind, data, ben).
REQ-031 Byte-enable storage SHALL be a sub-module dmem_array (one port, synchronous write, registered read).

Verification
REQ-032 Write 0xDEADBEEF, ben 0xF to 0x40 held; with WR_LATENCY=1, wr_ack SHALL be 1 in the cycle after BUSY and 0 otherwise.
REQ-033 Read 0x40 after REQ-032; rd_ack SHALL be 1 with RD_LATENCY=2 at cycle 3, and rd_data SHALL be 0xDEADBEEF.
REQ-034 Write 0x000000AA, ben 0x1 to 0x40, then read 0x40; rd_data SHALL be 0xDEADBEAA.
REQ-035 In DONE, present read 0x80 for 2 cycles, then re-present 0x40; acks SHALL be 0 during the 0x80 cycles and rd_ack SHALL be 1 on re-presentation.
REQ-036 Assert reset in BUSY of a write 0x11223344 to 0x44; a later read of 0x44 SHALL return the prior value, and the FSM SHALL be IDLE after reset.
REQ-037 With DMEM_RESP_BOUNDS_CHECK_EN and DEPTH_WORDS=1024, read 0x1000; rd_data SHALL be 0 and dmem_err SHALL be 1 with rd_ack. Without the macro, the same read SHALL alias word 0.
